// File: rtl/game_phase_ctrl.sv
// Battleship phase sequencer: counts ship placements, alternates firing turns, tallies hits, declares winner.
// All outputs registered, one-cycle latency from input pulse; pulse inputs, no backpressure (invalid pulses dropped).
module game_phase_ctrl #(
    parameter int NUM_SHIPS = 5,
    parameter int WIN_HITS  = 17,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ship_placed,
    input  logic             shot_fired,
    input  logic             shot_hit,
    output logic [2:0]       state,
    output logic [2:0]       p1_ships,
    output logic [2:0]       p2_ships,
    output logic [CNT_W-1:0] p1_hits,
    output logic [CNT_W-1:0] p2_hits,
    output logic [1:0]       winner,
    output logic             turn_change
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_PLACE  = 3'd1,
        P2_PLACE  = 3'd2,
        P1_FIRE   = 3'd3,
        P2_FIRE   = 3'd4,
        GAME_OVER = 3'd5
    } phase_t;

    localparam logic [2:0]       SHIP_LIM = 3'(NUM_SHIPS);
    localparam logic [CNT_W-1:0] HIT_LIM  = CNT_W'(WIN_HITS);

    phase_t           phase;
    logic [2:0]       p1_ships_nxt;
    logic [2:0]       p2_ships_nxt;
    logic [CNT_W-1:0] p1_hits_nxt;
    logic [CNT_W-1:0] p2_hits_nxt;

    assign state        = phase;
    assign p1_ships_nxt = p1_ships + 3'd1;
    assign p2_ships_nxt = p2_ships + 3'd1;
    assign p1_hits_nxt  = p1_hits + CNT_W'(1);
    assign p2_hits_nxt  = p2_hits + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= IDLE;
            p1_ships    <= '0;
            p2_ships    <= '0;
            p1_hits     <= '0;
            p2_hits     <= '0;
            winner      <= 2'd0;
            turn_change <= 1'b0;
        end else begin
            turn_change <= 1'b0;
            case (phase)
                IDLE, GAME_OVER: begin
                    // A new game always starts from a clean scoreboard.
                    if (start) begin
                        phase       <= P1_PLACE;
                        p1_ships    <= '0;
                        p2_ships    <= '0;
                        p1_hits     <= '0;
                        p2_hits     <= '0;
                        winner      <= 2'd0;
                        turn_change <= 1'b1;
                    end
                end
                P1_PLACE: begin
                    if (ship_placed) begin
                        p1_ships <= p1_ships_nxt;
                        if (p1_ships_nxt == SHIP_LIM) begin
                            phase       <= P2_PLACE;
                            turn_change <= 1'b1;
                        end
                    end
                end
                P2_PLACE: begin
                    if (ship_placed) begin
                        p2_ships <= p2_ships_nxt;
                        if (p2_ships_nxt == SHIP_LIM) begin
                            phase       <= P1_FIRE;
                            turn_change <= 1'b1;
                        end
                    end
                end
                P1_FIRE: begin
                    if (shot_fired) begin
                        turn_change <= 1'b1;
                        phase       <= P2_FIRE;
                        if (shot_hit) begin
                            p1_hits <= p1_hits_nxt;
                            if (p1_hits_nxt == HIT_LIM) begin
                                phase  <= GAME_OVER;
                                winner <= 2'd1;
                            end
                        end
                    end
                end
                P2_FIRE: begin
                    if (shot_fired) begin
                        turn_change <= 1'b1;
                        phase       <= P1_FIRE;
                        if (shot_hit) begin
                            p2_hits <= p2_hits_nxt;
                            if (p2_hits_nxt == HIT_LIM) begin
                                phase  <= GAME_OVER;
                                winner <= 2'd2;
                            end
                        end
                    end
                end
                default: begin
                    phase       <= IDLE;
                    turn_change <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl with NUM_SHIPS=2, WIN_HITS=3.
module tb_game_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ship_placed;
    logic       shot_fired;
    logic       shot_hit;
    logic [2:0] state;
    logic [2:0] p1_ships;
    logic [2:0] p2_ships;
    logic [4:0] p1_hits;
    logic [4:0] p2_hits;
    logic [1:0] winner;
    logic       turn_change;

    int checks = 0;
    int errors = 0;
    int tc_count = 0;
    int tc_base;

    game_phase_ctrl #(
        .NUM_SHIPS(2),
        .WIN_HITS (3),
        .CNT_W    (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ship_placed(ship_placed),
        .shot_fired (shot_fired),
        .shot_hit   (shot_hit),
        .state      (state),
        .p1_ships   (p1_ships),
        .p2_ships   (p2_ships),
        .p1_hits    (p1_hits),
        .p2_hits    (p2_hits),
        .winner     (winner),
        .turn_change(turn_change)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (turn_change === 1'b1) tc_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int st, input int s1, input int s2,
                            input int h1, input int h2, input int w);
        chk({tag, ".state"},    32'(state),    32'(st));
        chk({tag, ".p1_ships"}, 32'(p1_ships), 32'(s1));
        chk({tag, ".p2_ships"}, 32'(p2_ships), 32'(s2));
        chk({tag, ".p1_hits"},  32'(p1_hits),  32'(h1));
        chk({tag, ".p2_hits"},  32'(p2_hits),  32'(h2));
        chk({tag, ".winner"},   32'(winner),   32'(w));
    endtask

    task automatic step(input logic s, input logic sp, input logic sf, input logic sh);
        start       = s;
        ship_placed = sp;
        shot_fired  = sf;
        shot_hit    = sh;
        @(posedge clk);
        #1;
        start       = 1'b0;
        ship_placed = 1'b0;
        shot_fired  = 1'b0;
        shot_hit    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ship_placed = 1'b0;
        shot_fired  = 1'b0;
        shot_hit    = 1'b0;
        idle(2);
        reset = 1'b0;
        tc_base = tc_count;

        // Reset state and quiet idle
        idle(5);
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.tc_cnt", 32'(tc_count - tc_base), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle_ignore.state", 32'(state), 32'd0);
        chk("idle_ignore.tc", 32'(turn_change), 32'd0);

        // Placement
        tc_base = tc_count;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start.state", 32'(state), 32'd1);
        chk("start.tc", 32'(turn_change), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("p1_place1", 1, 1, 0, 0, 0, 0);
        chk("p1_place1.tc", 32'(turn_change), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("p1_place2", 2, 2, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("p2_place1", 2, 2, 1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_outs("p2_place2", 3, 2, 2, 0, 0, 0);
        idle(1);
        chk("place.tc_cnt", 32'(tc_count - tc_base), 32'd3);
        chk("place.tc_low", 32'(turn_change), 32'd0);

        // Firing
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_outs("p1_miss", 4, 2, 2, 0, 0, 0);
        chk("p1_miss.tc", 32'(turn_change), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("p2_hit", 3, 2, 2, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hit_no_fire.state", 32'(state), 32'd3);
        chk("hit_no_fire.p1_hits", 32'(p1_hits), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_outs("start_in_fire", 3, 2, 2, 0, 1, 0);
        chk("start_in_fire.tc", 32'(turn_change), 32'd0);

        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("p1_hit1", 4, 2, 2, 1, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("p2_miss1.state", 32'(state), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("p1_hit2", 4, 2, 2, 2, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("p2_miss2.state", 32'(state), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("p1_win", 5, 2, 2, 3, 1, 1);
        chk("p1_win.tc", 32'(turn_change), 32'd1);

        // Game over holds
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_outs("over_hold", 5, 2, 2, 3, 1, 1);
        chk("over_hold.tc", 32'(turn_change), 32'd0);

        // Restart clears everything
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_outs("restart", 1, 0, 0, 0, 0, 0);
        chk("restart.tc", 32'(turn_change), 32'd1);

        // Reach P2_FIRE with p1_hits=2, then reset mid-game
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("replace.state", 32'(state), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("pre_reset", 4, 2, 2, 2, 0, 0);
        reset      = 1'b1;
        shot_fired = 1'b1;
        shot_hit   = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        shot_fired = 1'b0;
        shot_hit   = 1'b0;
        chk_outs("mid_reset", 0, 0, 0, 0, 0, 0);
        chk("mid_reset.tc", 32'(turn_change), 32'd0);

        // Simultaneous place and fire in P1_PLACE
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_outs("both_pulses", 1, 1, 0, 0, 0, 0);

        // Player 2 wins
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("p2game.state", 32'(state), 32'd3);
        repeat (2) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b1);
        end
        chk_outs("p2_two_hits", 3, 2, 2, 0, 2, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_outs("p2_win", 5, 2, 2, 0, 3, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
